apd_hv_comp: RTL and testbench
==============================

APD_HV_COMP -- requirements
Module: apd_hv_comp

Interface
REQ-001 SHALL provide parameter DAC_W, default 12, DAC code width.
REQ-002 SHALL provide parameter AVG_LOG2, default 4, log2 of the averaging window depth (range 0..6).
REQ-003 SHALL provide parameter HV_RST, default 1150, DAC code presented from reset.
REQ-004 SHALL provide port i_clk_50m  in  1  system clock; reset i_rst_n, asynchronous, active-low; clock i_clk_50m.
REQ-005 SHALL provide port i_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL provide port i_update  in  1  one-cycle request to compute a new HV code.
REQ-007 SHALL provide port i_temp  in  8  device temperature, signed two's complement, 1 degC/LSB.
REQ-008 SHALL provide port i_temp_base  in  8  calibration temperature, signed, 1 degC/LSB.
REQ-009 SHALL provide port i_hv_base  in  16  HV code at i_temp_base.
REQ-010 SHALL provide port i_coe_hot / i_coe_cold  in  8 each  code/degC above / below base.
REQ-011 SHALL provide port i_hv_min / i_hv_max  in  DAC_W each  clamp limits.
REQ-012 SHALL provide port i_avg_bypass  in  1  1 = publish clamped sample without averaging.
REQ-013 SHALL provide port o_dac_start  out  1  one-cycle DAC write strobe.
REQ-014 SHALL provide port o_dac_value  out  DAC_W  code to DAC, stable between strobes.
REQ-015 SHALL provide port o_busy  out  1  high in every state except IDLE.
REQ-016 SHALL provide port o_clamp  out  1  last published sample was clamped; updated with o_dac_start.

Function
REQ-017 SHALL implement FSM IDLE -> MUL -> SUM -> AVG -> OUT -> IDLE, one cycle per non-IDLE state.
REQ-018 SHALL in IDLE on i_update=1 latch all data inputs; i_update outside IDLE SHALL be ignored (no queueing).
REQ-019 SHALL in MUL form diff = i_temp - i_temp_base as 9-bit signed, |diff| saturated to 255, product = coefficient(hot if diff>=0, cold if diff<0) x |diff|, 16-bit unsigned.
REQ-020 SHALL in SUM compute hv = i_hv_base +/- product in 18-bit signed, then clamp: hv<i_hv_min -> i_hv_min, hv>i_hv_max -> i_hv_max, clamp flag set; if i_hv_min>i_hv_max, result = i_hv_min, flag set.
REQ-021 SHALL in AVG maintain a 2^AVG_LOG2 ring buffer and running sum (DAC_W+AVG_LOG2 bits): sum <= sum - oldest + new, new overwrites oldest, write pointer wraps modulo depth.
REQ-022 SHALL on the first sample after reset fill every buffer entry with it and set sum = new << AVG_LOG2.
REQ-023 SHALL in OUT drive o_dac_value = sum >> AVG_LOG2 (or clamped sample if i_avg_bypass latched =1, buffer still updated) and pulse o_dac_start for exactly this cycle.
REQ-024 SHALL give fixed latency: i_update sampled at cycle N -> o_dac_start high at cycle N+4; next i_update accepted from cycle N+5.
REQ-025 SHALL never use truncated partial sums; average is exact floor of sum/depth.

Reset
REQ-026 SHALL on i_rst_n low asynchronously force state IDLE, o_dac_start=0, o_dac_value=HV_RST, o_clamp=0, o_busy=0, sum=0, pointer=0, filled flag=0.
REQ-027 SHALL on reset mid-computation discard the transaction with no strobe; next sample refills per REQ-022.

Structure
REQ-028 SHALL place the FSM state enum, HV_RST default and clamp-flag encoding in shared package apd_hv_pkg.
REQ-029 SHALL implement ring buffer plus running sum as sub-module hv_avg_ring (inputs: sample, write, fill; output: sum).

Verification
REQ-030 SHALL test hot: base 25, temp 35, hv_base 2000, coe_hot 3, bypass=1 -> o_dac_value 2030, o_clamp 0, strobe at N+4.
REQ-031 SHALL test cold: base 25, temp -5 (0xFB), hv_base 2000, coe_cold 2, bypass=1 -> 1940.
REQ-032 SHALL test clamp: hv_base 3990, temp 125, base 25, coe_hot 10, hv_max 4000 -> 4000, o_clamp 1; min 3000 > max 2000 -> 3000, o_clamp 1.
REQ-033 SHALL test averaging: after reset sample 2000 -> 2000; next sample 2160 -> 2010; 16 further samples 2160 -> 2160.
REQ-034 SHALL test i_update asserted during MUL..OUT -> ignored, exactly one strobe per accepted request.
REQ-035 SHALL test reset asserted in SUM -> no strobe, o_dac_value 1150, next sample 1800 -> 1800.

Source files
------------

// File: rtl/apd_hv_pkg.sv
// apd_hv_pkg: shared FSM states, reset HV code and clamp-flag encoding for the APD HV compensator
package apd_hv_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_SUM, ST_AVG, ST_OUT} state_t;
    localparam int HV_RST_DEF = 1150;
    localparam logic CLAMP_OFF = 1'b0;
    localparam logic CLAMP_ON  = 1'b1;
endpackage

// File: rtl/hv_avg_ring.sv
// hv_avg_ring: 2^AVG_LOG2-deep sample ring with exact running sum; fill preloads every entry
module hv_avg_ring #(
    parameter int DAC_W    = 12,
    parameter int AVG_LOG2 = 4
)(
    input  logic                      i_clk_50m,
    input  logic                      i_rst_n,
    input  logic [DAC_W-1:0]          i_sample,
    input  logic                      i_write,
    input  logic                      i_fill,
    output logic [DAC_W+AVG_LOG2-1:0] o_sum
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PW    = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int SW    = DAC_W + AVG_LOG2;
    logic [DAC_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [SW-1:0]    r_sum;
    logic [PW-1:0]    w_ptr_nxt;
    assign w_ptr_nxt = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign o_sum     = r_sum;
    always_ff @(posedge i_clk_50m)
        if (i_write)
            for (int i = 0; i < DEPTH; i++)
                if (i_fill || PW'(i) == r_ptr) r_mem[i] <= i_sample;
    always_ff @(posedge i_clk_50m or negedge i_rst_n)
        if (!i_rst_n) begin
            r_sum <= '0;
            r_ptr <= '0;
        end else if (i_write) begin
            r_sum <= i_fill ? SW'(i_sample) << AVG_LOG2 : r_sum - SW'(r_mem[r_ptr]) + SW'(i_sample);
            r_ptr <= w_ptr_nxt;
        end
endmodule

// File: rtl/apd_hv_comp.sv
// apd_hv_comp: temperature-compensated APD HV code with clamp and moving average, 4-cycle pipeline FSM
module apd_hv_comp import apd_hv_pkg::*; #(
    parameter int DAC_W    = 12,
    parameter int AVG_LOG2 = 4,
    parameter int HV_RST   = HV_RST_DEF
)(
    input  logic             i_clk_50m,
    input  logic             i_rst_n,
    input  logic             i_update,
    input  logic [7:0]       i_temp,
    input  logic [7:0]       i_temp_base,
    input  logic [15:0]      i_hv_base,
    input  logic [7:0]       i_coe_hot,
    input  logic [7:0]       i_coe_cold,
    input  logic [DAC_W-1:0] i_hv_min,
    input  logic [DAC_W-1:0] i_hv_max,
    input  logic             i_avg_bypass,
    output logic             o_dac_start,
    output logic [DAC_W-1:0] o_dac_value,
    output logic             o_busy,
    output logic             o_clamp
);
    state_t                    r_state, w_state_nxt;
    logic [7:0]                r_temp, r_temp_base, r_coe_hot, r_coe_cold;
    logic [15:0]               r_hv_base, r_prod;
    logic [DAC_W-1:0]          r_hv_min, r_hv_max, r_sample, r_dac_value;
    logic                      r_bypass, r_neg, r_clamp_pend, r_clamp, r_filled;
    logic [DAC_W+AVG_LOG2-1:0] w_sum;
    logic signed [8:0]         w_diff;
    logic [8:0]                w_mag;
    logic [7:0]                w_abs;
    logic signed [17:0]        w_hv, w_min, w_max;
    logic                      w_inv, w_lo, w_hi;
    logic [DAC_W-1:0]          w_clamped, w_out;

    assign w_diff    = {r_temp[7], r_temp} - {r_temp_base[7], r_temp_base};
    assign w_mag     = w_diff[8] ? 9'(-w_diff) : w_diff;
    assign w_abs     = w_mag[8] ? 8'hFF : w_mag[7:0];
    assign w_hv      = r_neg ? 18'(r_hv_base) - 18'(r_prod) : 18'(r_hv_base) + 18'(r_prod);
    assign w_min     = 18'(r_hv_min);
    assign w_max     = 18'(r_hv_max);
    assign w_inv     = r_hv_min > r_hv_max;
    assign w_lo      = w_hv < w_min;
    assign w_hi      = w_hv > w_max;
    assign w_clamped = (w_inv || w_lo) ? r_hv_min : w_hi ? r_hv_max : w_hv[DAC_W-1:0];
    assign w_out     = r_bypass ? r_sample : w_sum[AVG_LOG2 +: DAC_W];

    always_ff @(posedge i_clk_50m or negedge i_rst_n)
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = i_update ? ST_MUL : ST_IDLE;
            ST_MUL:  w_state_nxt = ST_SUM;
            ST_SUM:  w_state_nxt = ST_AVG;
            ST_AVG:  w_state_nxt = ST_OUT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The OUT cycle shows the fresh result directly; the registers hold it until the next strobe
    always_comb begin
        o_dac_start = r_state == ST_OUT;
        o_busy      = r_state != ST_IDLE;
        o_dac_value = o_dac_start ? w_out : r_dac_value;
        o_clamp     = o_dac_start ? r_clamp_pend : r_clamp;
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n)
        if (!i_rst_n) begin
            r_temp       <= '0;
            r_temp_base  <= '0;
            r_hv_base    <= '0;
            r_coe_hot    <= '0;
            r_coe_cold   <= '0;
            r_hv_min     <= '0;
            r_hv_max     <= '0;
            r_bypass     <= 1'b0;
            r_neg        <= 1'b0;
            r_prod       <= '0;
            r_sample     <= '0;
            r_clamp_pend <= CLAMP_OFF;
            r_clamp      <= CLAMP_OFF;
            r_filled     <= 1'b0;
            r_dac_value  <= DAC_W'(HV_RST);
        end else begin
            if (r_state == ST_IDLE && i_update) begin
                r_temp      <= i_temp;
                r_temp_base <= i_temp_base;
                r_hv_base   <= i_hv_base;
                r_coe_hot   <= i_coe_hot;
                r_coe_cold  <= i_coe_cold;
                r_hv_min    <= i_hv_min;
                r_hv_max    <= i_hv_max;
                r_bypass    <= i_avg_bypass;
            end
            if (r_state == ST_MUL) begin
                r_neg  <= w_diff[8];
                r_prod <= 16'(w_diff[8] ? r_coe_cold : r_coe_hot) * 16'(w_abs);
            end
            if (r_state == ST_SUM) begin
                r_sample     <= w_clamped;
                r_clamp_pend <= (w_inv || w_lo || w_hi) ? CLAMP_ON : CLAMP_OFF;
            end
            if (r_state == ST_AVG) r_filled <= 1'b1;
            if (r_state == ST_OUT) begin
                r_dac_value <= w_out;
                r_clamp     <= r_clamp_pend;
            end
        end

    hv_avg_ring #(.DAC_W(DAC_W), .AVG_LOG2(AVG_LOG2)) u_ring (
        .i_clk_50m (i_clk_50m),
        .i_rst_n   (i_rst_n),
        .i_sample  (r_sample),
        .i_write   (r_state == ST_AVG),
        .i_fill    (!r_filled),
        .o_sum     (w_sum)
    );
endmodule

// File: tb/tb_apd_hv_comp.sv
// tb_apd_hv_comp: directed table, corner sequences and random requests against a queue-based reference model
module tb_apd_hv_comp;
    localparam int DEPTH = 16;
    logic        clk = 1'b0, rst_n = 1'b0, upd = 1'b0, byp = 1'b0;
    logic [7:0]  temp = '0, tbase = '0, hot = '0, cold = '0;
    logic [15:0] hvb = '0;
    logic [11:0] mn = '0, mx = '0;
    logic        start, busy, clamp;
    logic [11:0] val;
    int          errors = 0, checks = 0;
    int          q[$];

    typedef struct {
        logic [7:0]  t, b;
        logic [15:0] hvb;
        logic [7:0]  h, c;
        logic [11:0] mn, mx;
        bit          byp;
        int          ev, ec;
        string       nm;
    } vec_t;

    apd_hv_comp dut (
        .i_clk_50m(clk), .i_rst_n(rst_n), .i_update(upd), .i_temp(temp), .i_temp_base(tbase),
        .i_hv_base(hvb), .i_coe_hot(hot), .i_coe_cold(cold), .i_hv_min(mn), .i_hv_max(mx),
        .i_avg_bypass(byp), .o_dac_start(start), .o_dac_value(val), .o_busy(busy), .o_clamp(clamp)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Compensated and clamped code from the rules, in plain integer arithmetic
    function automatic void model_hv(input vec_t v, output int s, output int f);
        int d, m, p, hv;
        d  = int'($signed(v.t)) - int'($signed(v.b));
        m  = d < 0 ? -d : d;
        if (m > 255) m = 255;
        p  = (d < 0 ? int'(v.c) : int'(v.h)) * m;
        hv = d < 0 ? int'(v.hvb) - p : int'(v.hvb) + p;
        if (v.mn > v.mx)           begin s = v.mn; f = 1; end
        else if (hv < int'(v.mn))  begin s = v.mn; f = 1; end
        else if (hv > int'(v.mx))  begin s = v.mx; f = 1; end
        else                       begin s = hv;   f = 0; end
    endfunction

    function automatic int model_avg(input int s);
        int acc = 0;
        if (q.size() == 0) repeat (DEPTH) q.push_back(s);
        else begin
            void'(q.pop_front());
            q.push_back(s);
        end
        foreach (q[i]) acc += q[i];
        return acc / DEPTH;
    endfunction

    task automatic run(input vec_t v, input bit spam);
        int s, f, ev, ec, n, strobes;
        model_hv(v, s, f);
        ev = model_avg(s);
        if (v.byp) ev = s;
        if (v.ev >= 0) ev = v.ev;
        ec = v.ec >= 0 ? v.ec : f;
        temp = v.t; tbase = v.b; hvb = v.hvb; hot = v.h; cold = v.c;
        mn = v.mn; mx = v.mx; byp = v.byp; upd = 1'b1;
        @(negedge clk);
        if (!spam) upd = 1'b0;
        n = 1;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({v.nm, "_latency"}, n, 4);
        chk({v.nm, "_value"}, int'(val), ev);
        chk({v.nm, "_clamp"}, int'(clamp), ec);
        @(negedge clk);
        upd = 1'b0;
        chk({v.nm, "_strobe_width"}, int'(start), 0);
        chk({v.nm, "_hold"}, int'(val), ev);
        if (spam) begin
            strobes = 0;
            repeat (8) begin
                @(negedge clk);
                strobes += int'(start);
            end
            chk({v.nm, "_extra_strobes"}, strobes, 0);
        end
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   strobes;
        tbl[0] = '{8'd35,  8'd25,  16'd2000,  8'd3,   8'd0,   12'd0,    12'd4095, 1'b1, 2030, 0, "hot"};
        tbl[1] = '{8'hFB,  8'd25,  16'd2000,  8'd0,   8'd2,   12'd0,    12'd4095, 1'b1, 1940, 0, "cold"};
        tbl[2] = '{8'd125, 8'd25,  16'd3990,  8'd10,  8'd0,   12'd0,    12'd4000, 1'b1, 4000, 1, "clamp_max"};
        tbl[3] = '{8'd25,  8'd25,  16'd2500,  8'd0,   8'd0,   12'd3000, 12'd2000, 1'b1, 3000, 1, "min_gt_max"};
        tbl[4] = '{8'h80,  8'h7F,  16'd100,   8'd0,   8'd255, 12'd500,  12'd4000, 1'b1, 500,  1, "clamp_neg"};
        tbl[5] = '{8'h7F,  8'h80,  16'd65535, 8'd255, 8'd0,   12'd0,    12'd4095, 1'b1, 4095, 1, "clamp_wide"};

        repeat (3) @(negedge clk);
        chk("rst_value", int'(val), 1150);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clamp", int'(clamp), 0);
        rst_n = 1'b1;
        @(negedge clk);

        v = '{8'd25, 8'd25, 16'd2000, 8'd3, 8'd2, 12'd0, 12'd4095, 1'b0, 2000, 0, "avg_first"};
        run(v, 1'b0);
        v.hvb = 16'd2160; v.ev = 2010; v.nm = "avg_second";
        run(v, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            v.ev = i == DEPTH - 1 ? 2160 : -1;
            v.nm = i == DEPTH - 1 ? "avg_settled" : "avg_ramp";
            run(v, 1'b0);
        end

        foreach (tbl[i]) run(tbl[i], 1'b0);

        v = '{8'd30, 8'd25, 16'd1500, 8'd4, 8'd1, 12'd0, 12'd4095, 1'b1, 1520, 0, "busy_ignore"};
        run(v, 1'b1);

        for (int i = 0; i < 150; i++) begin
            v.t   = 8'($urandom);
            v.b   = 8'($urandom);
            v.hvb = $urandom_range(0, 7) == 0 ? 16'($urandom) : 16'($urandom_range(0, 4095));
            v.h   = 8'($urandom_range(0, 20));
            v.c   = 8'($urandom_range(0, 20));
            v.mn  = 12'($urandom_range(0, 1500));
            v.mx  = 12'($urandom_range(1000, 4095));
            v.byp = 1'($urandom);
            v.ev  = -1; v.ec = -1; v.nm = "random";
            run(v, 1'b0);
        end

        temp = 8'd40; tbase = 8'd25; hvb = 16'd2222; hot = 8'd2; byp = 1'b0; upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_value", int'(val), 1150);
        strobes = int'(start);
        repeat (6) begin
            @(negedge clk);
            strobes += int'(start);
        end
        chk("midrst_strobes", strobes, 0);
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_idle_value", int'(val), 1150);
        v = '{8'd25, 8'd25, 16'd1800, 8'd3, 8'd2, 12'd0, 12'd4095, 1'b0, 1800, 0, "refill"};
        run(v, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
